// File: rtl/qa_drv_umf_packer_if.sv
// Client-chunk / cache-line bundle between the UMF tester stage, the packer
// and the to-host FIFO writer. The packer connects through the slave view.
interface qa_drv_umf_packer_if #(
   parameter int UMF_WIDTH   = 128,
   parameter int CACHE_WIDTH = 512
);
   logic [UMF_WIDTH-1:0]   tx_data;
   logic                   tx_enable;
   logic                   tx_rdy;
   logic                   flush;
   logic [CACHE_WIDTH-1:0] line_data;
   logic [2:0]             line_chunks;
   logic                   line_valid;
   logic                   line_deq;
   logic [31:0]            stat_lines;
   logic [31:0]            stat_partial;

   // Packer side: consumes chunks, produces lines and statistics.
   modport slave (
      input  tx_data, tx_enable, flush, line_deq,
      output tx_rdy, line_data, line_chunks, line_valid, stat_lines, stat_partial
   );

   // Environment side: pushes chunks, dequeues lines.
   modport master (
      output tx_data, tx_enable, flush, line_deq,
      input  tx_rdy, line_data, line_chunks, line_valid, stat_lines, stat_partial
   );
endinterface

// File: rtl/qa_drv_umf_packer.sv
// Packs UMF_WIDTH-bit client chunks into CACHE_WIDTH-bit lines. A line is
// emitted when full, or partially on flush / idle timeout, into a single
// output register that the to-host FIFO dequeues.
module qa_drv_umf_packer #(
   parameter int UMF_WIDTH     = 128,
   parameter int CACHE_WIDTH   = 512,
   parameter int FLUSH_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               resetb,
   qa_drv_umf_packer_if.slave bus
);
   localparam int         CHUNKS = CACHE_WIDTH / UMF_WIDTH;
   localparam int         IDLE_W = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [2:0] FULL   = 3'(CHUNKS);

   logic [UMF_WIDTH-1:0]   slot_q [CHUNKS];
   logic [2:0]             fill_q;
   logic [IDLE_W-1:0]      idle_q;
   logic [CACHE_WIDTH-1:0] line_data_q;
   logic [2:0]             line_chunks_q;
   logic                   line_valid_q;
   logic [31:0]            stat_lines_q;
   logic [31:0]            stat_partial_q;

   logic                   tx_rdy;
   logic                   accept;
   logic                   out_free;
   logic                   timeout;
   logic                   emit;
   logic [2:0]             fill_pre;
   logic [CACHE_WIDTH-1:0] line_d;

   // Ready depends only on registered fill, never on the consumer's dequeue.
   assign tx_rdy   = (fill_q != FULL);
   assign accept   = bus.tx_enable && tx_rdy;
   assign fill_pre = fill_q + {2'b00, accept};
   assign out_free = !line_valid_q || bus.line_deq;
   assign timeout  = (FLUSH_TIMEOUT != 0) && (32'(idle_q) >= 32'(FLUSH_TIMEOUT));
   assign emit     = out_free && ((fill_pre == FULL) ||
                                  ((fill_pre != 3'd0) && (bus.flush || timeout)));

   genvar gi;
   generate
      for (gi = 0; gi < CHUNKS; gi++) begin : g_slot
         // Line image includes the chunk accepted this cycle; slots above the
         // fill level may hold stale data from a previous line, so zero them.
         assign line_d[gi*UMF_WIDTH +: UMF_WIDTH] =
            (3'(gi) < fill_pre) ?
               ((accept && (fill_q == 3'(gi))) ? bus.tx_data : slot_q[gi]) :
               '0;

         // Capture an accepted chunk into the slot addressed by the fill level.
         always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
               slot_q[gi] <= '0;
            end else if (accept && (fill_q == 3'(gi))) begin
               slot_q[gi] <= bus.tx_data;
            end
         end
      end
   endgenerate

   // Fill level, idle timer, output line register and statistics.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         fill_q         <= '0;
         idle_q         <= '0;
         line_data_q    <= '0;
         line_chunks_q  <= '0;
         line_valid_q   <= 1'b0;
         stat_lines_q   <= '0;
         stat_partial_q <= '0;
      end else begin
         if (emit) begin
            line_data_q   <= line_d;
            line_chunks_q <= fill_pre;
            line_valid_q  <= 1'b1;
            fill_q        <= '0;
            stat_lines_q  <= stat_lines_q + 32'd1;
            if (fill_pre != FULL) begin
               stat_partial_q <= stat_partial_q + 32'd1;
            end
         end else begin
            fill_q <= fill_pre;
            if (bus.line_deq) begin
               line_valid_q <= 1'b0;
            end
         end

         // Idle timer only runs while a partial line waits in the slots.
         if (accept || emit || (fill_q == 3'd0)) begin
            idle_q <= '0;
         end else if (idle_q != '1) begin
            idle_q <= idle_q + 1'b1;
         end
      end
   end

   assign bus.tx_rdy       = tx_rdy;
   assign bus.line_data    = line_data_q;
   assign bus.line_chunks  = line_chunks_q;
   assign bus.line_valid   = line_valid_q;
   assign bus.stat_lines   = stat_lines_q;
   assign bus.stat_partial = stat_partial_q;
endmodule

// File: tb/tb_qa_drv_umf_packer.sv
// Directed bench for qa_drv_umf_packer (FLUSH_TIMEOUT=8), followed by a short
// random run checked against a chunk queue.
module tb_qa_drv_umf_packer;
   logic clk = 1'b0;
   logic resetb;
   int   errors = 0;
   int   checks = 0;
   int   exp_lines;
   int   exp_partial;
   logic [127:0] sb_q [$];

   always #5 clk = ~clk;

   qa_drv_umf_packer_if #(.UMF_WIDTH(128), .CACHE_WIDTH(512)) bus ();

   qa_drv_umf_packer #(
      .UMF_WIDTH    (128),
      .CACHE_WIDTH  (512),
      .FLUSH_TIMEOUT(8)
   ) dut (
      .clk   (clk),
      .resetb(resetb),
      .bus   (bus.slave)
   );

   task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mk4(input logic [127:0] s0, input logic [127:0] s1,
                                        input logic [127:0] s2, input logic [127:0] s3);
      return {s3, s2, s1, s0};
   endfunction

   // Pushing while not ready is a protocol error on the bench side.
   always @(negedge clk) begin
      if (resetb && bus.tx_enable) begin
         check_val("protocol_push_ready", bus.tx_rdy, 1);
      end
   end

   task automatic check_reset(input string tag);
      check_val({tag, "_rdy"},     bus.tx_rdy,       1);
      check_val({tag, "_valid"},   bus.line_valid,   0);
      check_val({tag, "_chunks"},  bus.line_chunks,  0);
      check_val({tag, "_data"},    bus.line_data,    0);
      check_val({tag, "_lines"},   bus.stat_lines,   0);
      check_val({tag, "_partial"}, bus.stat_partial, 0);
   endtask

   // Pops line_chunks entries off the queue and compares the whole line.
   task automatic score_line();
      logic [511:0] exp;
      int n;
      n = int'(bus.line_chunks);
      check_val("rnd_chunks_range", (n >= 1 && n <= 4), 1);
      exp = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < n && sb_q.size() > 0) exp[k*128 +: 128] = sb_q.pop_front();
      end
      check_val("rnd_line", bus.line_data, exp);
      exp_lines++;
      if (n < 4) exp_partial++;
      $display("line %0d chunks=%0d data=%0h", exp_lines, n, bus.line_data[127:0]);
   endtask

   initial begin
      logic [31:0] seq;
      logic        en;
      resetb        = 1'b0;
      bus.tx_data   = '0;
      bus.tx_enable = 1'b0;
      bus.flush     = 1'b0;
      bus.line_deq  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      resetb = 1'b1;
      tick();

      // Streaming: 16 chunks back to back, consumer always ready.
      bus.line_deq = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         bus.tx_data   = 128'(i);
         bus.tx_enable = 1'b1;
         check_val("stream_rdy", bus.tx_rdy, 1);
         tick();
         check_val("stream_valid", bus.line_valid, (i % 4) == 0);
         if ((i % 4) == 0) begin
            check_val("stream_data", bus.line_data,
                      mk4(128'(i - 3), 128'(i - 2), 128'(i - 1), 128'(i)));
            check_val("stream_chunks", bus.line_chunks, 4);
            $display("stream line ending chunk %0d", i);
         end
      end
      bus.tx_enable = 1'b0;
      tick();
      check_val("stream_drained", bus.line_valid, 0);
      check_val("stream_lines", bus.stat_lines, 4);
      check_val("stream_partial", bus.stat_partial, 0);

      // Timeout: two chunks then idle; line appears 10 cycles after the last.
      bus.line_deq  = 1'b0;
      bus.tx_data   = 128'hA;
      bus.tx_enable = 1'b1;
      tick();
      bus.tx_data   = 128'hB;
      tick();
      bus.tx_enable = 1'b0;
      repeat (8) tick();
      check_val("tmo_early", bus.line_valid, 0);
      tick();
      check_val("tmo_valid", bus.line_valid, 1);
      check_val("tmo_chunks", bus.line_chunks, 2);
      check_val("tmo_data", bus.line_data, mk4(128'hA, 128'hB, 128'h0, 128'h0));
      check_val("tmo_lines", bus.stat_lines, 5);
      check_val("tmo_partial", bus.stat_partial, 1);
      $display("timeout line chunks=%0d", bus.line_chunks);
      bus.line_deq = 1'b1;
      tick();
      bus.line_deq = 1'b0;
      check_val("tmo_deq", bus.line_valid, 0);

      // Flush colliding with a push: the pushed chunk joins the flushed line.
      bus.tx_enable = 1'b1;
      bus.tx_data   = 128'h21;
      tick();
      bus.tx_data   = 128'h22;
      tick();
      bus.tx_data   = 128'hC;
      bus.flush     = 1'b1;
      tick();
      bus.tx_enable = 1'b0;
      bus.flush     = 1'b0;
      check_val("flush_valid", bus.line_valid, 1);
      check_val("flush_chunks", bus.line_chunks, 3);
      check_val("flush_data", bus.line_data, mk4(128'h21, 128'h22, 128'hC, 128'h0));
      check_val("flush_lines", bus.stat_lines, 6);
      check_val("flush_partial", bus.stat_partial, 2);
      $display("flush line chunks=%0d", bus.line_chunks);
      bus.line_deq = 1'b1;
      tick();
      bus.line_deq = 1'b0;
      bus.flush    = 1'b1;
      repeat (3) tick();
      bus.flush    = 1'b0;
      check_val("flush_empty_valid", bus.line_valid, 0);
      check_val("flush_empty_lines", bus.stat_lines, 6);

      // Backpressure: eight chunks fill output plus assembly, then stall.
      for (int i = 0; i < 8; i++) begin
         bus.tx_data   = 128'(32'h31 + i);
         bus.tx_enable = 1'b1;
         check_val("bp_rdy_fill", bus.tx_rdy, 1);
         tick();
      end
      bus.tx_enable = 1'b0;
      check_val("bp_rdy_low", bus.tx_rdy, 0);
      check_val("bp_hold_valid", bus.line_valid, 1);
      check_val("bp_hold_data", bus.line_data, mk4(128'h31, 128'h32, 128'h33, 128'h34));
      repeat (2) tick();
      check_val("bp_rdy_still_low", bus.tx_rdy, 0);
      check_val("bp_hold_data2", bus.line_data, mk4(128'h31, 128'h32, 128'h33, 128'h34));
      bus.tx_data  = 128'h39;
      bus.line_deq = 1'b1;
      tick();
      bus.line_deq = 1'b0;
      check_val("bp_next_valid", bus.line_valid, 1);
      check_val("bp_next_data", bus.line_data, mk4(128'h35, 128'h36, 128'h37, 128'h38));
      check_val("bp_next_chunks", bus.line_chunks, 4);
      check_val("bp_rdy_back", bus.tx_rdy, 1);
      bus.tx_enable = 1'b1;
      tick();
      bus.tx_enable = 1'b0;
      bus.flush     = 1'b1;
      tick();
      check_val("bp_flush_blocked", bus.line_data, mk4(128'h35, 128'h36, 128'h37, 128'h38));
      bus.line_deq = 1'b1;
      tick();
      bus.line_deq = 1'b0;
      bus.flush    = 1'b0;
      check_val("bp_ninth_data", bus.line_data, mk4(128'h39, 128'h0, 128'h0, 128'h0));
      check_val("bp_ninth_chunks", bus.line_chunks, 1);
      check_val("bp_lines", bus.stat_lines, 9);
      check_val("bp_partial", bus.stat_partial, 3);
      $display("backpressure ninth chunk line chunks=%0d", bus.line_chunks);
      bus.line_deq = 1'b1;
      tick();
      bus.line_deq = 1'b0;

      // Asynchronous reset with a held line and a partial assembly.
      for (int i = 0; i < 7; i++) begin
         bus.tx_data   = 128'(32'h41 + i);
         bus.tx_enable = 1'b1;
         tick();
      end
      bus.tx_enable = 1'b0;
      check_val("rst_pre_valid", bus.line_valid, 1);
      check_val("rst_pre_rdy", bus.tx_rdy, 1);
      resetb = 1'b0;
      #2;
      check_reset("async_reset");
      @(posedge clk);
      #1;
      resetb        = 1'b1;
      bus.tx_data   = 128'h51;
      bus.tx_enable = 1'b1;
      bus.flush     = 1'b1;
      tick();
      bus.tx_enable = 1'b0;
      bus.flush     = 1'b0;
      check_val("rst_after_valid", bus.line_valid, 1);
      check_val("rst_after_chunks", bus.line_chunks, 1);
      check_val("rst_after_data", bus.line_data, mk4(128'h51, 128'h0, 128'h0, 128'h0));
      check_val("rst_after_lines", bus.stat_lines, 1);
      $display("post-reset line chunks=%0d", bus.line_chunks);
      bus.line_deq = 1'b1;
      tick();
      bus.line_deq = 1'b0;
      exp_lines   = 1;
      exp_partial = 1;

      // Random push/flush/dequeue mix against the chunk queue.
      seq = 32'd0;
      for (int c = 0; c < 3000; c++) begin
         bus.line_deq  = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 15) == 0);
         en            = bus.tx_rdy && ($urandom_range(0, 2) != 0);
         bus.tx_enable = en;
         bus.tx_data   = {32'hC0DE_0000 + seq, seq, ~seq, seq};
         if (bus.line_valid && bus.line_deq) score_line();
         if (en) begin
            sb_q.push_back(bus.tx_data);
            seq++;
         end
         tick();
      end
      bus.tx_enable = 1'b0;
      bus.flush     = 1'b1;
      bus.line_deq  = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (bus.line_valid) score_line();
         tick();
      end
      bus.flush    = 1'b0;
      bus.line_deq = 1'b0;
      check_val("drain_queue_empty", sb_q.size(), 0);
      check_val("drain_valid", bus.line_valid, 0);
      check_val("rnd_stat_lines", bus.stat_lines, 32'(exp_lines));
      check_val("rnd_stat_partial", bus.stat_partial, 32'(exp_partial));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/qa_drv_umf_packer.md
# qa_drv_umf_packer

Packs 128-bit UMF chunks from the client transmit FIFO interface into 512-bit cache lines for the to-host memory-mapped FIFO writer. It sits between the tester/loopback stage (tx_data/tx_enable/tx_rdy) and the to-host FIFO, which writes each line it receives to host memory. Partial lines are flushed on an explicit request or after a programmable idle timeout, so short messages are not stranded in the packer.

## Interface
- UMF_WIDTH, 128, width of one client chunk.
- CACHE_WIDTH, 512, line width; CHUNKS = CACHE_WIDTH/UMF_WIDTH = 4; must divide exactly.
- FLUSH_TIMEOUT, 64, idle cycles before a partial line is emitted; 0 disables the timeout.

Ports:
- clk  in  1  CCI 32ui clock. Single clock domain.
- resetb  in  1  reset, asynchronous, active-low.
- tx_data  in  UMF_WIDTH  chunk from client.
- tx_enable  in  1  push; legal only while tx_rdy=1.
- tx_rdy  out  1  packer can accept a chunk this cycle.
- flush  in  1  level; emit any partial line as soon as possible.
- line_data  out  CACHE_WIDTH  packed line; chunk k in bits [k*UMF_WIDTH +: UMF_WIDTH].
- line_chunks  out  3  number of valid chunks in line_data, 1..4.
- line_valid  out  1  output register holds a line.
- line_deq  in  1  consumer takes the line; only sampled when line_valid=1.
- stat_lines  out  32  total lines emitted.
- stat_partial  out  32  lines emitted with line_chunks<4.

## Operation
- Storage: assembly register (4 slots, fill counter 0..4), one output register (line_data/line_chunks/line_valid), idle counter (saturating, ceil(log2(FLUSH_TIMEOUT+1)) bits, minimum 1).
- tx_rdy = (fill != 4); registered state only, no path from line_deq.
- accept = tx_enable && tx_rdy; chunk written to slot[fill]; fill_pre = fill + accept.
- out_free = !line_valid || line_deq.
- timeout = (FLUSH_TIMEOUT != 0) && (idle_cnt >= FLUSH_TIMEOUT).
- emit = out_free && (fill_pre == 4 || (fill_pre > 0 && (flush || timeout))).
- On emit: output register <= assembly contents including this cycle's accepted chunk; unused slots driven to zero; line_chunks <= fill_pre; line_valid <= 1; fill <= 0; stat_lines++; stat_partial++ if fill_pre < 4.
- No emit: fill <= fill_pre; if line_deq, line_valid <= 0.
- fill==4 and out not free: hold; tx_rdy=0 until consumer dequeues; the full line emits in the same cycle line_deq is seen.
- idle_cnt: cleared on accept or emit; else incremented (saturating) while fill>0; held at 0 while fill==0.
- flush with fill==0 and no accept: no effect; never emits an empty line.
- Chunk order preserved end-to-end; no chunk dropped or duplicated.
- Stat counters wrap modulo 2^32.
- tx_enable while tx_rdy=0: ignored (no accept). Bench flags it as a protocol error.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert from the system): fill=0, idle_cnt=0, line_valid=0, line_chunks=0, line_data=0, stat_lines=0, stat_partial=0, tx_rdy=1. Reset mid-line discards the assembly and the output register.
- Full-line latency: 4th chunk accepted at edge t with out free -> line_valid=1 after edge t (visible cycle t+1).
- Throughput: 1 chunk/cycle sustained while consumer asserts line_deq whenever line_valid; no bubbles at line boundaries.
- Timeout: last chunk accepted at cycle t, no further traffic -> idle_cnt reaches T at cycle t+1+T -> line_valid at cycle t+2+T.
- Flush: flush high at cycle c with fill>0 and out free -> line_valid at c+1.
- Backpressure: line_deq held 0 -> at most 4 chunks (one line) accepted beyond the line held in the output register; tx_rdy drops in the cycle after the 4th is accepted.

## Test plan
- Streaming: 16 chunks 0x1..0x10 on consecutive cycles, line_deq tied 1 -> 4 lines, first line_data = {0x4,0x3,0x2,0x1}, line_chunks=4 each, tx_rdy never 0, stat_lines=4, stat_partial=0.
- Timeout: FLUSH_TIMEOUT=8, push 0xA,0xB then idle -> one line at cycle t+10 with line_chunks=2, upper 256 bits zero, stat_partial=1.
- Flush collision: fill=2, assert flush in same cycle as push of 0xC -> line_chunks=3 containing 0xC in slot 2.
- Backpressure: line_deq=0, push 9 chunks -> only 8 accepted, tx_rdy=0 from then on; pulse line_deq -> next line presented in the following cycle, tx_rdy=1 after that edge, ninth chunk accepted and order intact.
- Reset mid-operation: fill=3, line_valid=1, assert resetb=0 asynchronously -> all outputs return to reset values without a clock edge; after release, first pushed chunk lands in slot 0.
- Random: constrained-random push/flush/line_deq for 100k cycles -> scoreboard proves in-order, lossless delivery and stat counters match.
